// File: rtl/router_crossbar.sv
// Output-stage crossbar of the NoC router: steers each input flit to the output
// named by its self-excluding one-hot grant, with optional SSA write merge and output register.
module router_crossbar #(
  parameter int    V                         = 4,
  parameter int    P                         = 5,
  parameter int    Fpay                      = 32,
  parameter string MUX_TYPE                  = "ONE_HOT",
  parameter int    ADD_PIPREG_AFTER_CROSSBAR = 0,
  parameter string SSA_EN                    = "YES",
  localparam int   P_1                       = P - 1,
  localparam int   Fw                        = 2 + V + Fpay,
  localparam int   PFw                       = P * Fw
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [P*P_1-1:0] granted_dest_port_all,
  input  logic [PFw-1:0]   flit_in_all,
  input  logic [P-1:0]     ssa_flit_wr_all,
  output logic [PFw-1:0]   flit_out_all,
  output logic [P-1:0]     flit_out_we_all
);

  logic [P-1:0][P_1-1:0] grant;
  logic [P-1:0][Fw-1:0]  flit_in;
  logic [P-1:0][Fw-1:0]  mux_flit;
  logic [P-1:0][P-1:0]   req;       // req[o][i]: input i targets output o
  logic [P-1:0]          req_any;
  logic [P-1:0]          we_comb;

  assign grant   = granted_dest_port_all;
  assign flit_in = flit_in_all;

  // Grant bit j of input i names output j below i, or j+1 at/above i.
  for (genvar o = 0; o < P; o++) begin : g_out
    for (genvar i = 0; i < P; i++) begin : g_in
      if (i == o) begin : g_self
        assign req[o][i] = 1'b0;
      end else begin : g_map
        localparam int J = (o < i) ? o : o - 1;
        assign req[o][i] = grant[i][J];
      end
    end
    assign req_any[o] = |req[o];
  end

  if (SSA_EN == "YES") begin : g_ssa
    assign we_comb = req_any | ssa_flit_wr_all;
  end else begin : g_no_ssa
    logic unused_ssa;
    assign we_comb    = req_any;
    assign unused_ssa = ^ssa_flit_wr_all;
  end

  if (MUX_TYPE == "BINARY") begin : g_binary
    localparam int IW = (P > 1) ? $clog2(P) : 1;
    logic [P-1:0][IW-1:0] sel_idx;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
      sel_idx  = '0;
      mux_flit = '0;
      for (int o = 0; o < P; o++) begin
        // Scanning downward leaves the lowest-index requester selected.
        for (int i = P - 1; i >= 0; i--) begin
          if (req[o][i]) sel_idx[o] = IW'(i);
        end
        if (req_any[o]) mux_flit[o] = flit_in[sel_idx[o]];
      end
    end
  end else begin : g_one_hot
    always_comb begin
      mux_flit = '0;
      for (int o = 0; o < P; o++) begin
        for (int i = 0; i < P; i++) begin
          mux_flit[o] = mux_flit[o] | ({Fw{req[o][i]}} & flit_in[i]);
        end
      end
    end
  end

  if (ADD_PIPREG_AFTER_CROSSBAR != 0) begin : g_pipreg
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        flit_out_all    <= '0;
        flit_out_we_all <= '0;
      end else begin
        flit_out_all    <= mux_flit;
        flit_out_we_all <= we_comb;
      end
    end
  end else begin : g_comb_out
    logic unused_clk_reset;
    assign flit_out_all     = mux_flit;
    assign flit_out_we_all  = we_comb;
    assign unused_clk_reset = clk ^ reset;
  end

endmodule

// File: tb/tb_router_crossbar.sv
// Directed scoreboard bench for router_crossbar: combinational ONE_HOT/SSA, BINARY/no-SSA
// and registered instances share the same stimulus.
module tb_router_crossbar;

  localparam int P   = 5;
  localparam int P_1 = 4;
  localparam int Fw  = 38;
  localparam int PFw = P * Fw;

  localparam logic [Fw-1:0] FA = 38'h1_0000_000A;
  localparam logic [Fw-1:0] FB = 38'h2_0000_000B;
  localparam logic [Fw-1:0] FC = 38'h3_0000_000C;
  localparam logic [Fw-1:0] FD = 38'h2A_5555_000D;
  localparam logic [Fw-1:0] FE = 38'h3F_FFFF_000E;
  localparam logic [Fw-1:0] Z  = '0;

  typedef struct {
    string            tag;
    logic [PFw-1:0]   f_oh;
    logic [P-1:0]     we_oh;
    logic [PFw-1:0]   f_bin;
    logic [P-1:0]     we_bin;
  } comb_exp_t;

  typedef struct {
    string            tag;
    logic [PFw-1:0]   f;
    logic [P-1:0]     we;
  } pipe_exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic [P*P_1-1:0] grant;
  logic [PFw-1:0]   flit_in;
  logic [P-1:0]     ssa;
  logic [PFw-1:0]   f_oh, f_bin, f_pipe;
  logic [P-1:0]     we_oh, we_bin, we_pipe;

  comb_exp_t comb_q[$];
  pipe_exp_t pipe_q[$];
  int        checks = 0;
  int        errors = 0;

  always #5 clk = ~clk;

  router_crossbar #(.V(4), .P(5), .Fpay(32), .MUX_TYPE("ONE_HOT"),
                    .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("YES")) dut_oh (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
    .ssa_flit_wr_all(ssa), .flit_out_all(f_oh), .flit_out_we_all(we_oh));

  router_crossbar #(.V(4), .P(5), .Fpay(32), .MUX_TYPE("BINARY"),
                    .ADD_PIPREG_AFTER_CROSSBAR(0), .SSA_EN("NO")) dut_bin (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
    .ssa_flit_wr_all(ssa), .flit_out_all(f_bin), .flit_out_we_all(we_bin));

  router_crossbar #(.V(4), .P(5), .Fpay(32), .MUX_TYPE("ONE_HOT"),
                    .ADD_PIPREG_AFTER_CROSSBAR(1), .SSA_EN("YES")) dut_pipe (
    .clk(clk), .reset(reset), .granted_dest_port_all(grant), .flit_in_all(flit_in),
    .ssa_flit_wr_all(ssa), .flit_out_all(f_pipe), .flit_out_we_all(we_pipe));

  function automatic logic [P*P_1-1:0] g(logic [3:0] g0, logic [3:0] g1, logic [3:0] g2,
                                         logic [3:0] g3, logic [3:0] g4);
    return {g4, g3, g2, g1, g0};
  endfunction

  function automatic logic [PFw-1:0] fl(logic [Fw-1:0] f0, logic [Fw-1:0] f1, logic [Fw-1:0] f2,
                                        logic [Fw-1:0] f3, logic [Fw-1:0] f4);
    return {f4, f3, f2, f1, f0};
  endfunction

  task automatic check(string tag, logic [PFw-1:0] got_f, logic [PFw-1:0] exp_f,
                       logic [P-1:0] got_we, logic [P-1:0] exp_we);
    checks++;
    assert (got_f === exp_f && got_we === exp_we) else begin
      errors++;
      $error("FAIL %s: flit=%h we=%b, expected flit=%h we=%b", tag, got_f, got_we, exp_f, exp_we);
    end
  endtask

  // Drive one combinational step and compare both combinational instances.
  task automatic comb_step(string tag, logic [P*P_1-1:0] gr, logic [PFw-1:0] fi, logic [P-1:0] s,
                           logic [PFw-1:0] e_f_oh, logic [P-1:0] e_we_oh,
                           logic [PFw-1:0] e_f_bin, logic [P-1:0] e_we_bin);
    comb_exp_t e;
    @(negedge clk);
    grant   = gr;
    flit_in = fi;
    ssa     = s;
    comb_q.push_back('{tag, e_f_oh, e_we_oh, e_f_bin, e_we_bin});
    #1;
    e = comb_q.pop_front();
    check({e.tag, "/one_hot"}, f_oh, e.f_oh, we_oh, e.we_oh);
    check({e.tag, "/binary"}, f_bin, e.f_bin, we_bin, e.we_bin);
  endtask

  task automatic pipe_compare();
    pipe_exp_t e;
    e = pipe_q.pop_front();
    check(e.tag, f_pipe, e.f, we_pipe, e.we);
  endtask

  initial begin
    logic [PFw-1:0] all_flits;
    logic [PFw-1:0] perm_out;
    all_flits = fl(FA, FB, FC, FD, FE);
    perm_out  = fl(FE, FA, FB, FC, FD);

    reset   = 1'b1;
    grant   = '0;
    flit_in = '0;
    ssa     = '0;
    #1;
    check("reset/pipe_zero", f_pipe, '0, we_pipe, '0);
    check("reset/comb_idle", f_oh, '0, we_oh, '0);

    // Combinational behaviour; reset stays high to show it does not touch these outputs.
    comb_step("basic_map", g(4'b0001, 4'b0, 4'b0, 4'b0, 4'b0), fl(38'h1234, FB, FC, FD, FE), 5'b0,
              fl(Z, 38'h1234, Z, Z, Z), 5'b00010, fl(Z, 38'h1234, Z, Z, Z), 5'b00010);
    comb_step("in3_to_out4", g(4'b0, 4'b0, 4'b0, 4'b1000, 4'b0), all_flits, 5'b0,
              fl(Z, Z, Z, Z, FD), 5'b10000, fl(Z, Z, Z, Z, FD), 5'b10000);
    comb_step("in3_to_out2", g(4'b0, 4'b0, 4'b0, 4'b0100, 4'b0), all_flits, 5'b0,
              fl(Z, Z, FD, Z, Z), 5'b00100, fl(Z, Z, FD, Z, Z), 5'b00100);
    comb_step("in1_to_out0", g(4'b0, 4'b0001, 4'b0, 4'b0, 4'b0), all_flits, 5'b0,
              fl(FB, Z, Z, Z, Z), 5'b00001, fl(FB, Z, Z, Z, Z), 5'b00001);
    comb_step("in4_to_out3", g(4'b0, 4'b0, 4'b0, 4'b0, 4'b1000), all_flits, 5'b0,
              fl(Z, Z, Z, FE, Z), 5'b01000, fl(Z, Z, Z, FE, Z), 5'b01000);
    comb_step("permutation", g(4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001), all_flits, 5'b0,
              perm_out, 5'b11111, perm_out, 5'b11111);
    comb_step("ssa_only", '0, all_flits, 5'b00100,
              '0, 5'b00100, '0, 5'b00000);
    comb_step("multi_req", g(4'b0010, 4'b0010, 4'b0, 4'b0, 4'b0), all_flits, 5'b0,
              fl(Z, Z, FA | FB, Z, Z), 5'b00100, fl(Z, Z, FA, Z, Z), 5'b00100);
    check("pipe_held_in_reset", f_pipe, '0, we_pipe, '0);

    // Registered instance: one-cycle latency.
    @(negedge clk);
    reset   = 1'b0;
    grant   = g(4'b0, 4'b0, 4'b0001, 4'b0, 4'b0);
    flit_in = all_flits;
    ssa     = '0;
    pipe_q.push_back('{"pipe_in2_out0_n+1", fl(FC, Z, Z, Z, Z), 5'b00001});
    #1;
    check("pipe_in2_out0_n", f_pipe, '0, we_pipe, '0);
    @(posedge clk);
    #1;
    pipe_compare();

    @(negedge clk);
    grant = g(4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001);
    pipe_q.push_back('{"pipe_permutation", perm_out, 5'b11111});
    @(posedge clk);
    #1;
    pipe_compare();

    // Mid-stream async reset clears the register before the next edge.
    #2;
    reset = 1'b1;
    #1;
    check("pipe_async_reset", f_pipe, '0, we_pipe, '0);
    check("comb_ignores_reset", f_oh, perm_out, we_oh, 5'b11111);

    @(negedge clk);
    reset = 1'b0;
    pipe_q.push_back('{"pipe_first_edge_after_reset", perm_out, 5'b11111});
    @(posedge clk);
    #1;
    pipe_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/router_crossbar.md
# router_crossbar

Output-stage switch of the NoC router. It routes each input port's flit to the output port selected by that input's one-hot destination grant and drives one write-enable per output port. The switch allocator produces the grants, and the router delays them by one cycle before they reach this block. A speculative (SSA) write path and an optional output pipeline register are supported.

## Interface
- V, 4: VCs per port. Used only for the flit width.
- P, 5: number of router ports.
- Fpay, 32: payload width. Flit width Fw = 2+V+Fpay (38 with defaults).
- MUX_TYPE, "ONE_HOT": mux implementation, "ONE_HOT" (AND-OR) or "BINARY" (one-hot to index, then indexed select).
- ADD_PIPREG_AFTER_CROSSBAR, 0: when 1, flit and write-enable outputs are registered.
- SSA_EN, "YES": when "YES", ssa_flit_wr_all is merged into the write enables. When "NO", that input is ignored.
- Derived: P_1 = P-1; PFw = P*Fw.

Ports:
- clk  in  1  clock.
- reset  in  1  reset: asynchronous, active-high.
- granted_dest_port_all  in  P*P_1  field i = bits [(i+1)*P_1-1 : i*P_1]: one-hot destination grant of input port i.
- flit_in_all  in  PFw  field i = flit from input port i.
- ssa_flit_wr_all  in  P  bit o = speculative-bypass write for output port o.
- flit_out_all  out  PFw  field o = flit driven to output port o.
- flit_out_we_all  out  P  bit o = output port o write enable.

## Operation
- Self-excluding encoding: bit j of input i's field selects output o = j if j < i, else o = j+1. An input never targets itself.
- Per output o, req[o][i] = the bit of input i's field that maps to o (i ≠ o). This gives P_1 candidate inputs per output.
- flit_out[o] = flit_in[i] for the requesting i.
  - No requester: flit_out[o] = all zeros in both mux types.
  - Multiple requesters (allocator violation): ONE_HOT gives the bitwise OR of the requesting flits. BINARY gives the lowest-index requesting input.
- we[o] = OR over i of req[o][i]. If SSA_EN=="YES", we[o] |= ssa_flit_wr_all[o].
- For an SSA-only write, the flit data comes from the same mux. The input port is responsible for presenting the correct grant.
- ONE_HOT and BINARY give identical outputs whenever each output has at most one requester.
- The block holds no state other than the optional pipeline register.

## Timing
- ADD_PIPREG_AFTER_CROSSBAR=0:
  - Fully combinational; flit_out_all and flit_out_we_all follow their inputs in the same cycle.
  - reset has no effect on the outputs.
- ADD_PIPREG_AFTER_CROSSBAR=1:
  - The combinational result is captured on posedge clk; latency is 1 cycle.
  - Reset value of flit_out_all = 0 and flit_out_we_all = 0. Assertion clears both immediately (async) at any time, including mid-packet.
  - The first edge after deassertion captures the current inputs.
- Simultaneous grants to different outputs are independent and all pass in the same cycle. Full P-way permutation throughput: one flit per output per cycle.

## Test plan
All cases use P=5, V=4, Fpay=32 (Fw=38).
- Basic map: input0 field=4'b0001, flit_in0=38'h1234 → flit_out1=38'h1234, flit_out_we=5'b00010, all other flit_out = 0.
- Self-exclusion:
  - input3 field=4'b1000 → output4 gets flit_in3.
  - input3 field=4'b0100 → output2 gets flit_in3.
  - input1 field=4'b0001 → output0 gets flit_in1.
- Permutation: inputs 0..4 target outputs 1,2,3,4,0 with distinct flits A..E → flit_out0..4 = E,A,B,C,D and we=5'b11111. Run in both MUX_TYPEs; outputs must be identical.
- SSA: all grants 0, ssa_flit_wr_all=5'b00100 → we=5'b00100 with SSA_EN="YES", and we=5'b00000 with SSA_EN="NO".
- Pipeline (ADD_PIPREG=1):
  - Grant input2→output0 at cycle n → flit_out0/we[0] appear at cycle n+1 and stay 0 at cycle n.
  - Assert reset mid-stream → outputs go to 0 before the next clk edge.
